qspi_stream_scheduler: RTL and testbench
========================================

Name: qspi_stream_scheduler

Overview:
- Shares the single QSPI flash read controller between two consumers: the video instruction stream and the PWM audio sample stream.
- Holds one wrapping read pointer per stream and issues fixed-length read bursts to the flash controller. It routes the returned 19-bit words to the stream that owns the current burst.
- Sits between the QSPI controller and the video data buffers / audio sample FIFO, and decides which stream is fetched next.

Parameters:
- ADDR_W, 24, width of word-address pointers and of cmd_addr
- DATA_W, 19, width of a flash word (instruction/sample)
- VID_BASE, 24'h000000, first word address of the video region
- VID_END, 24'h3FFFFF, last word address of the video region (inclusive)
- AUD_BASE, 24'h400000, first word address of the audio region
- AUD_END, 24'h7FFFFF, last word address of the audio region (inclusive)
- VID_BURST, 16, words per video burst (>=1)
- AUD_BURST, 4, words per audio burst (>=1)

Ports:
- clk, input, 1, pixel clock
- rst_n, input, 1, asynchronous active-low reset
- vid_need, input, 1, video buffers below refill threshold (level)
- aud_need, input, 1, audio FIFO below refill threshold (level)
- vid_rewind, input, 1, pulse: restart video at VID_BASE (frame/loop restart)
- cmd_start, output, 1, one-cycle pulse: flash controller begins read at cmd_addr
- cmd_addr, output, ADDR_W, start word address for the burst
- cmd_stop, output, 1, one-cycle pulse: flash controller ends the transaction
- ctrl_busy, input, 1, flash controller transaction in progress
- word_valid, input, 1, word_data valid this cycle
- word_data, input, DATA_W, word returned by the flash controller
- vid_valid, output, 1, word_data belongs to video
- aud_valid, output, 1, word_data belongs to audio
- out_data, output, DATA_W, registered copy of word_data
- grant_aud, output, 1, current/last burst owner (0 = video, 1 = audio)

Behaviour:
- Reset (async, rst_n low): state IDLE; vid_ptr=VID_BASE; aud_ptr=AUD_BASE; all pulse/valid outputs 0; cmd_addr=0; out_data=0; grant_aud=0; rewind_pend=0. Reset mid-burst drops the burst and issues no cmd_stop; the flash controller is reset by the same rst_n.
- FSM:
  - IDLE: if ctrl_busy=0 and (aud_need or vid_need), select an owner. aud_need has fixed priority. Latch grant_aud and cmd_addr = owner pointer. Go to START.
  - START: cmd_start=1 for exactly one cycle; clear word counter; go to STREAM.
  - STREAM: each word_valid registers word_data into out_data; the next cycle pulses vid_valid or aud_valid per grant_aud (1-cycle latency). The owner pointer increments with each word. After the BURSTth word, go to STOP.
  - STOP: cmd_stop=1 for one cycle; go to WAIT.
  - WAIT: stay until ctrl_busy=0, then go to IDLE.
- No preemption: a burst always completes. Audio priority applies only at IDLE decisions.
- Starvation guard: after 2 consecutive audio bursts with vid_need high, the next decision goes to video.
- Pointer wrap: a pointer at its END increments to its BASE. A burst may straddle the wrap; cmd_stop+restart at the wrap point is required: the word at END ends the burst early (go to STOP) and the remainder is fetched in the next burst.
- vid_rewind:
  - In IDLE, vid_ptr=VID_BASE immediately.
  - Otherwise, or if it coincides with a video burst, set rewind_pend and apply it at the next IDLE entry. It overrides the increment.
  - Words of a video burst already in flight are still delivered.
- vid_need/aud_need dropping mid-burst does not shorten the burst.
- word_valid outside STREAM is ignored. vid_valid and aud_valid are never both 1.

Optional Feature:
- QSPI_STREAM_AUDIO_EN defined: full two-stream arbitration as above.
- Not defined:
  - aud_need is ignored and aud_ptr is not built.
  - aud_valid=0 and grant_aud=0 constantly.
  - Every burst is video.
  - The starvation counter is not built.

Decomposition:
- Shared package qspi_stream_pkg: FSM state enum (IDLE, START, STREAM, STOP, WAIT), ADDR_W/DATA_W defaults, STARVE_LIMIT=2.
- One natural sub-module, stream_pointer: a wrapping BASE..END counter with load-to-base, increment, and an at_end flag. It is instantiated twice, the audio instance under the macro.

Test Plan:
- Video only: vid_need=1, VID_BURST=16, controller returns 1 word/cycle -> cmd_start with cmd_addr=0; 16 vid_valid pulses 1 cycle after each word_valid; cmd_stop after the 16th word; next cmd_addr=16.
- Both needing: vid_need=aud_need=1 held -> burst order audio, audio, video, audio, audio, video. Audio addresses 0x400000, 0x400004; video 0x000000.
- Wrap: vid_ptr preloaded near VID_END=0x00000F, VID_BURST=16, start 0x00000C -> burst ends after 4 words. Next cmd_addr=0x000000.
- Rewind during a video burst at vid_ptr=0x20 -> remaining words delivered; next video cmd_addr=0x000000.
- Reset asserted in STREAM -> outputs 0 asynchronously; after release, first cmd_addr=AUD_BASE with aud_need=1.
- Macro undefined, aud_need=1, vid_need=0 -> no cmd_start, aud_valid stays 0.

Source files
------------

// File: rtl/qspi_stream_pkg.sv
// Shared types and defaults for the QSPI stream scheduler.
package qspi_stream_pkg;

  localparam int unsigned ADDR_W       = 24;
  localparam int unsigned DATA_W       = 19;
  localparam int unsigned STARVE_LIMIT = 2;
  localparam int unsigned STARVE_W     = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    STREAM = 3'd2,
    STOP   = 3'd3,
    WAIT   = 3'd4
  } state_e;

endpackage

// File: rtl/stream_pointer.sv
// Wrapping BASE..END word-address counter with load-to-base and increment.
module stream_pointer #(
  parameter int unsigned       ADDR_W = qspi_stream_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter logic [ADDR_W-1:0] END    = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_base,
  input  logic              incr,
  output logic [ADDR_W-1:0] ptr,
  output logic              at_end_c
);
  import qspi_stream_pkg::*;

  logic [ADDR_W-1:0] r_ptr;

  assign at_end_c = (r_ptr == END);
  assign ptr      = r_ptr;

  // Load to base wins over increment; END wraps to BASE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= BASE;
    end else if (load_base) begin
      r_ptr <= BASE;
    end else if (incr) begin
      r_ptr <= at_end_c ? BASE : r_ptr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/qspi_stream_scheduler.sv
// Shares one QSPI read controller between the video and audio streams.
// Optional feature macro: QSPI_STREAM_AUDIO_EN (audio stream + arbitration).
module qspi_stream_scheduler #(
  parameter int unsigned       ADDR_W    = qspi_stream_pkg::ADDR_W,
  parameter int unsigned       DATA_W    = qspi_stream_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] VID_BASE  = 24'h000000,
  parameter logic [ADDR_W-1:0] VID_END   = 24'h3FFFFF,
  parameter logic [ADDR_W-1:0] AUD_BASE  = 24'h400000,
  parameter logic [ADDR_W-1:0] AUD_END   = 24'h7FFFFF,
  parameter int unsigned       VID_BURST = 16,
  parameter int unsigned       AUD_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_need,
  input  logic              aud_need,
  input  logic              vid_rewind,
  output logic              cmd_start,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              cmd_stop,
  input  logic              ctrl_busy,
  input  logic              word_valid,
  input  logic [DATA_W-1:0] word_data,
  output logic              vid_valid,
  output logic              aud_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              grant_aud
);
  import qspi_stream_pkg::*;

  localparam int unsigned MAX_BURST = (VID_BURST > AUD_BURST) ? VID_BURST : AUD_BURST;
  localparam int unsigned CNT_W     = $clog2(MAX_BURST + 1);

  state_e             r_state, w_next;
  logic               r_cmd_start, w_cmd_start_n;
  logic               r_cmd_stop, w_cmd_stop_n;
  logic [ADDR_W-1:0]  r_cmd_addr, w_cmd_addr_n;
  logic               r_grant_aud, w_grant_n;
  logic [CNT_W-1:0]   r_cnt, w_cnt_n, w_cnt_inc;
  logic               r_rew_pend, w_rew_pend_n;
  logic               r_vid_valid, r_aud_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic               w_take;
  logic               w_issue;
  logic               w_pick_aud;
  logic               w_aud_req;
  logic               w_vid_load, w_vid_incr, w_aud_incr;
  logic [ADDR_W-1:0]  w_vid_ptr, w_aud_ptr;
  logic               w_vid_at_end, w_aud_at_end;
  logic               w_owner_at_end;
  logic [CNT_W-1:0]   w_burst_len;

  // Video read pointer.
  stream_pointer #(
    .ADDR_W (ADDR_W),
    .BASE   (VID_BASE),
    .END    (VID_END)
  ) u_vid_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_base (w_vid_load),
    .incr      (w_vid_incr),
    .ptr       (w_vid_ptr),
    .at_end_c  (w_vid_at_end)
  );

`ifdef QSPI_STREAM_AUDIO_EN
  logic [STARVE_W-1:0] r_starve, w_starve_n;

  // Audio read pointer.
  stream_pointer #(
    .ADDR_W (ADDR_W),
    .BASE   (AUD_BASE),
    .END    (AUD_END)
  ) u_aud_ptr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_base (1'b0),
    .incr      (w_aud_incr),
    .ptr       (w_aud_ptr),
    .at_end_c  (w_aud_at_end)
  );

  assign w_aud_req  = aud_need;
  assign w_pick_aud = aud_need && !(vid_need && (r_starve >= STARVE_W'(STARVE_LIMIT)));

  // Count consecutive audio grants taken while video was also waiting.
  always_comb begin
    w_starve_n = r_starve;
    if ((r_state == IDLE) && w_issue) begin
      w_starve_n = (w_pick_aud && vid_need) ? r_starve + STARVE_W'(1) : '0;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else begin
      r_starve <= w_starve_n;
    end
  end
`else
  logic w_unused_cfg;

  assign w_aud_req    = 1'b0;
  assign w_pick_aud   = 1'b0;
  assign w_aud_ptr    = AUD_BASE;
  assign w_aud_at_end = 1'b0;
  assign w_unused_cfg = aud_need ^ (^AUD_END) ^ w_aud_incr;
`endif

  assign w_issue        = !ctrl_busy && (w_aud_req || vid_need);
  assign w_owner_at_end = r_grant_aud ? w_aud_at_end : w_vid_at_end;
  assign w_burst_len    = r_grant_aud ? CNT_W'(AUD_BURST) : CNT_W'(VID_BURST);
  assign w_cnt_inc      = r_cnt + CNT_W'(1);

  // Next-state and next-output decode.
  always_comb begin
    w_next        = r_state;
    w_cmd_start_n = 1'b0;
    w_cmd_stop_n  = 1'b0;
    w_cmd_addr_n  = r_cmd_addr;
    w_grant_n     = r_grant_aud;
    w_cnt_n       = r_cnt;
    w_rew_pend_n  = r_rew_pend | vid_rewind;
    w_vid_load    = 1'b0;
    w_vid_incr    = 1'b0;
    w_aud_incr    = 1'b0;
    w_take        = 1'b0;
    case (r_state)
      IDLE: begin
        w_rew_pend_n = 1'b0;
        w_vid_load   = vid_rewind;
        if (w_issue) begin
          w_next        = START;
          w_cmd_start_n = 1'b1;
          w_grant_n     = w_pick_aud;
          w_cmd_addr_n  = w_pick_aud ? w_aud_ptr : (vid_rewind ? VID_BASE : w_vid_ptr);
        end
      end
      START: begin
        w_next  = STREAM;
        w_cnt_n = '0;
      end
      STREAM: begin
        if (word_valid) begin
          w_take     = 1'b1;
          w_cnt_n    = w_cnt_inc;
          w_aud_incr = r_grant_aud;
          w_vid_incr = !r_grant_aud;
          // A word at the region end closes the burst early.
          if ((w_cnt_inc == w_burst_len) || w_owner_at_end) begin
            w_next       = STOP;
            w_cmd_stop_n = 1'b1;
          end
        end
      end
      STOP: begin
        w_next = WAIT;
      end
      WAIT: begin
        if (!ctrl_busy) begin
          w_next       = IDLE;
          w_vid_load   = r_rew_pend | vid_rewind;
          w_rew_pend_n = 1'b0;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cmd_start <= 1'b0;
      r_cmd_stop  <= 1'b0;
      r_cmd_addr  <= '0;
      r_grant_aud <= 1'b0;
      r_cnt       <= '0;
      r_rew_pend  <= 1'b0;
      r_vid_valid <= 1'b0;
      r_aud_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state     <= w_next;
      r_cmd_start <= w_cmd_start_n;
      r_cmd_stop  <= w_cmd_stop_n;
      r_cmd_addr  <= w_cmd_addr_n;
      r_grant_aud <= w_grant_n;
      r_cnt       <= w_cnt_n;
      r_rew_pend  <= w_rew_pend_n;
      r_vid_valid <= w_take && !r_grant_aud;
      r_aud_valid <= w_take && r_grant_aud;
      if (w_take) begin
        r_out_data <= word_data;
      end
    end
  end

  assign cmd_start = r_cmd_start;
  assign cmd_stop  = r_cmd_stop;
  assign cmd_addr  = r_cmd_addr;
  assign grant_aud = r_grant_aud;
  assign vid_valid = r_vid_valid;
  assign aud_valid = r_aud_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_qspi_stream_scheduler.sv
// Scoreboard bench for qspi_stream_scheduler with a behavioural flash model.
module tb_qspi_stream_scheduler;

  localparam logic [23:0] VB = 24'h000000;
  localparam logic [23:0] VE = 24'h00002B;
  localparam logic [23:0] AB = 24'h400000;
  localparam logic [23:0] AE = 24'h40000D;
  localparam int VBURST = 16;
  localparam int ABURST = 4;
`ifdef QSPI_STREAM_AUDIO_EN
  localparam bit AUD_EN = 1'b1;
`else
  localparam bit AUD_EN = 1'b0;
`endif

  logic        clk, rst_n;
  logic        vid_need, aud_need, vid_rewind;
  logic        cmd_start, cmd_stop, ctrl_busy;
  logic [23:0] cmd_addr;
  logic        word_valid;
  logic [18:0] word_data;
  logic        vid_valid, aud_valid, grant_aud;
  logic [18:0] out_data;

  qspi_stream_scheduler #(
    .ADDR_W(24), .DATA_W(19),
    .VID_BASE(VB), .VID_END(VE), .AUD_BASE(AB), .AUD_END(AE),
    .VID_BURST(VBURST), .AUD_BURST(ABURST)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_need(vid_need), .aud_need(aud_need), .vid_rewind(vid_rewind),
    .cmd_start(cmd_start), .cmd_addr(cmd_addr), .cmd_stop(cmd_stop),
    .ctrl_busy(ctrl_busy), .word_valid(word_valid), .word_data(word_data),
    .vid_valid(vid_valid), .aud_valid(aud_valid), .out_data(out_data),
    .grant_aud(grant_aud)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        aud;
    logic [18:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   m_bursts = 0;
  int   m_words = 0;
  int   quiet = 0;
  int   fl_cnt = 0;

  // Flash content: a fixed scramble of the word address.
  function automatic logic [18:0] wdata(input logic [23:0] a);
    logic [31:0] x;
    x = {8'h00, a} * 32'h0000_9E37 + 32'h0000_0055;
    return 19'(x ^ (x >> 11));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Flash controller model: streams sequential words from cmd_addr until cmd_stop,
  // and throws junk words at the scheduler when it should not be listening.
  initial begin
    logic        active;
    logic [23:0] faddr;
    int          hold;
    active = 1'b0; faddr = '0; hold = 0;
    ctrl_busy = 1'b0; word_valid = 1'b0; word_data = '0;
    forever begin
      @(posedge clk); #1;
      word_valid = 1'b0;
      if (!rst_n) begin
        active = 1'b0; ctrl_busy = 1'b0; hold = 0; fl_cnt = 0;
      end else if (cmd_start) begin
        active = 1'b1; faddr = cmd_addr; fl_cnt = 0; ctrl_busy = 1'b1;
        if ($urandom_range(3) == 0) begin word_valid = 1'b1; word_data = 19'($urandom); end
      end else if (cmd_stop) begin
        active = 1'b0; hold = $urandom_range(3);
        if ($urandom_range(1) == 0) begin word_valid = 1'b1; word_data = 19'($urandom); end
      end else if (active) begin
        if ($urandom_range(3) != 0) begin
          word_valid = 1'b1; word_data = wdata(faddr);
          faddr = faddr + 24'd1; fl_cnt++;
        end
      end else if (ctrl_busy) begin
        if (hold == 0) ctrl_busy = 1'b0;
        else begin
          hold--;
          if ($urandom_range(1) == 0) begin word_valid = 1'b1; word_data = 19'($urandom); end
        end
      end
    end
  end

  // Idle detector: no transaction and no effective request for consecutive cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (!ctrl_busy && !cmd_start && !vid_need && !(aud_need && AUD_EN)) quiet++;
      else quiet = 0;
    end
  end

  // Reference model and monitor: predicts each burst at cmd_start, checks every output word.
  initial begin
    logic [23:0] m_vid, m_aud, start;
    int   m_starve, cur_n, s, e, n, nxt;
    bit   m_rew, own, vneed, aneed;
    exp_t got, want;
    m_vid = VB; m_aud = AB; m_starve = 0; m_rew = 1'b0; cur_n = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete(); m_vid = VB; m_aud = AB; m_starve = 0; m_rew = 1'b0; cur_n = -1;
      end else begin
        if (vid_rewind) m_rew = 1'b1;
        if (vid_valid || aud_valid) begin
          chk("valid_exclusive", 32'(vid_valid & aud_valid), 32'd0);
          got.aud = aud_valid; got.data = out_data;
          if (sb.size() == 0) begin
            chk("unexpected_word", {12'd0, got.aud, got.data}, 32'hFFFF_FFFF);
          end else begin
            want = sb.pop_front();
            chk("word_owner_data", {12'd0, got.aud, got.data}, {12'd0, want.aud, want.data});
            m_words++;
          end
        end
        if (cmd_start) begin
          vneed = vid_need; aneed = aud_need && AUD_EN;
          chk("start_has_request", 32'(vneed | aneed), 32'd1);
          if (m_rew) begin m_vid = VB; m_rew = 1'b0; end
          own = aneed && !(vneed && m_starve >= 2);
          m_starve = own ? (vneed ? m_starve + 1 : 0) : 0;
          start = own ? m_aud : m_vid;
          chk("cmd_addr", 32'(cmd_addr), 32'(start));
          chk("grant_aud", 32'(grant_aud), 32'(own));
          s = int'(start);
          e = own ? int'(AE) : int'(VE);
          n = (own ? ABURST : VBURST);
          if (e - s + 1 < n) n = e - s + 1;
          for (int i = 0; i < n; i++) begin
            want.aud = own; want.data = wdata(24'(s + i));
            sb.push_back(want);
          end
          nxt = (s + n - 1 == e) ? (own ? int'(AB) : int'(VB)) : s + n;
          if (own) m_aud = 24'(nxt); else m_vid = 24'(nxt);
          cur_n = n;
          m_bursts++;
        end
        if (cmd_stop) begin
          chk("burst_length", 32'(fl_cnt), 32'(cur_n));
          cur_n = -1;
        end
      end
    end
  end

  // Change requests only where the scheduler cannot be mid-decision.
  task automatic set_needs(input bit v, input bit a);
    int k;
    k = 0;
    while (!((ctrl_busy && !cmd_start) || quiet >= 3) && k < 800) begin
      @(posedge clk); #2; k++;
    end
    chk("needs_window", 32'(k < 800), 32'd1);
    vid_need = v; aud_need = a;
  endtask

  task automatic wait_bursts(input int target, input int limit);
    int k;
    k = 0;
    while (m_bursts < target && k < limit) begin @(posedge clk); #2; k++; end
    chk("burst_progress", 32'(m_bursts >= target), 32'd1);
  endtask

  task automatic wait_quiet(input int q);
    int k;
    k = 0;
    while (quiet < q && k < 1000) begin @(posedge clk); #2; k++; end
    chk("reach_idle", 32'(quiet >= q), 32'd1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_cmd_start", 32'(cmd_start), 32'd0);
    chk("rst_cmd_stop",  32'(cmd_stop),  32'd0);
    chk("rst_cmd_addr",  32'(cmd_addr),  32'd0);
    chk("rst_vid_valid", 32'(vid_valid), 32'd0);
    chk("rst_aud_valid", 32'(aud_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_grant_aud", 32'(grant_aud), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [1:0] r;
    rst_n = 1'b0; vid_need = 1'b0; aud_need = 1'b0; vid_rewind = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs();
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #2;

    // Video only: 0x00, 0x10, 0x20 (wraps after 12), 0x00.
    set_needs(1'b1, 1'b0);
    wait_bursts(m_bursts + 4, 800);

    // Both requesting: two audio bursts then video, repeatedly.
    set_needs(1'b1, 1'b1);
    wait_bursts(m_bursts + 6, 1200);

    // Rewind during a video burst; in-flight words still arrive.
    set_needs(1'b1, 1'b0);
    k = 0;
    while (!(ctrl_busy && !cmd_start && !grant_aud && sb.size() > 2) && k < 800) begin
      @(posedge clk); #2; k++;
    end
    chk("rewind_window", 32'(k < 800), 32'd1);
    vid_rewind = 1'b1;
    @(posedge clk); #2; vid_rewind = 1'b0;
    wait_bursts(m_bursts + 2, 800);

    // Rewind while idle, then resume video.
    set_needs(1'b0, 1'b0);
    wait_quiet(3);
    vid_rewind = 1'b1;
    @(posedge clk); #2; vid_rewind = 1'b0;
    set_needs(1'b1, 1'b0);
    wait_bursts(m_bursts + 1, 400);

    // Audio request alone; without the audio build nothing may start.
    set_needs(1'b0, 1'b1);
    repeat (80) begin @(posedge clk); #2; end

    // Randomised requests and rewinds.
    k = 0;
    while (m_bursts < 60 && k < 8000) begin
      @(posedge clk); #2; k++;
      vid_rewind = 1'b0;
      if (ctrl_busy && !cmd_start) begin
        if ($urandom_range(15) == 0) begin vid_need = 1'($urandom); aud_need = 1'($urandom); end
        if ($urandom_range(40) == 0) vid_rewind = 1'b1;
      end else if (quiet >= 3) begin
        r = 2'($urandom_range(1, 3));
        vid_need = r[0]; aud_need = r[1];
      end
    end
    @(posedge clk); #2; vid_rewind = 1'b0;
    chk("random_progress", 32'(m_bursts >= 60), 32'd1);

    // Asynchronous reset in the middle of a burst.
    set_needs(1'b1, 1'b1);
    k = 0;
    while (!(m_words > 0 && sb.size() > 1 && !cmd_stop) && k < 800) begin
      @(posedge clk); #2; k++;
    end
    chk("reset_window", 32'(k < 800), 32'd1);
    #1; rst_n = 1'b0;
    #1; check_reset_outputs();
    repeat (2) @(posedge clk);
    #3; rst_n = 1'b1;
    @(posedge clk); #2;
    wait_bursts(m_bursts + 3, 800);

    // Drain and confirm every predicted word arrived.
    set_needs(1'b0, 1'b0);
    wait_quiet(5);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
